ifu_prefetch: RTL and testbench

- Parametrised instruction-fetch front end with a DEPTH-entry in-order prefetch queue, up to MAX_OS outstanding memory requests, and redirect/flush support.
- Drives the instruction-memory req/rsp interface and presents decoded IR, PC, rs1idx and rs2idx to the EXU through a valid/ready port.
- Sits between instruction memory and the EXU.

---
 rtl/ifu_prefetch_pkg.sv | 31 +++
 rtl/ifu_pfq.sv | 71 +++++++
 rtl/ifu_prefetch.sv | 220 ++++++++++++++++++++++
 tb/tb_ifu_prefetch.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_prefetch_pkg
// Description : Shared constants and types for the instruction-fetch front end:
//               JAL opcode, sequential PC step, queue-entry layout and the
//               fetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_prefetch_pkg;

    // RV32 JAL major opcode
    localparam logic [6:0] c_opc_jal = 7'b1101111;

    // Sequential fetch step in bytes
    localparam int unsigned c_pc_inc = 4;

    // Queue entry layout at the default 32-bit widths; the queue itself packs
    // {instr, pc} in this same order for any width
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } pfq_entry_t;

    // Fetch controller states
    typedef enum logic [0:0] {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } ifu_state_e;

endpackage : ifu_prefetch_pkg
`default_nettype wire

// File: rtl/ifu_pfq.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pfq
// Description : Parametrised synchronous FIFO with flush, used as the
//               in-order prefetch queue. Exposes occupancy and the head entry.
//               Pushes into a full queue and pops from an empty queue are
//               ignored. rst is asynchronous, active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_pfq #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int c_ptr_w = $clog2(DEPTH),
    localparam int c_cnt_w = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   head_data,
    output logic [c_cnt_w-1:0] count
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push    = push && (r_count != c_cnt_w'(DEPTH));
    assign w_pop     = pop && (r_count != '0);
    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage array; contents are only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush empties the queue regardless of push/pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : ifu_pfq
`default_nettype wire

// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_prefetch
// Description : Instruction-fetch front end. Issues in-order fetch requests
//               under a credit rule (queue + outstanding <= DEPTH), queues
//               responses, and presents the head instruction with its PC and
//               rs1/rs2 indices to the EXU. Redirects flush the queue and
//               discard every response still in flight.
//               Optional macro IFU_JAL_PRED_EN: an enqueued JAL triggers an
//               internal redirect to its target on the following cycle.
//               rst is asynchronous, active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int RFIDX_W = 5,
    parameter int DEPTH   = 4,
    parameter int MAX_OS  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc_rtvec,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               ifu_req_valid,
    input  logic               ifu_req_ready,
    output logic [PC_W-1:0]    ifu_req_pc,
    input  logic               ifu_rsp_valid,
    output logic               ifu_rsp_ready,
    input  logic [INSTR_W-1:0] ifu_rsp_instr,
    output logic               ifu_o_valid,
    input  logic               ifu_o_ready,
    output logic [INSTR_W-1:0] ifu_o_ir,
    output logic [PC_W-1:0]    ifu_o_pc,
    output logic [RFIDX_W-1:0] ifu_o_rs1idx,
    output logic [RFIDX_W-1:0] ifu_o_rs2idx,
    output logic               ifu_o_pc_vld
);

    localparam int c_os_w  = $clog2(MAX_OS + 1);
    localparam int c_q_w   = $clog2(DEPTH + 1);
    localparam int c_sum_w = c_q_w + 1;
    localparam int c_ent_w = INSTR_W + PC_W;
    localparam logic [PC_W-1:0] c_inc   = PC_W'(c_pc_inc);
    localparam logic [PC_W-1:0] c_align = {{(PC_W-2){1'b1}}, 2'b00};

    ifu_state_e           r_state;
    ifu_state_e           w_state_nxt;
    logic [PC_W-1:0]      r_fetch_pc;
    logic [PC_W-1:0]      r_rsp_pc;
    logic [c_os_w-1:0]    r_os_cnt;
    logic [c_q_w-1:0]     r_drop_cnt;
    logic [c_ent_w-1:0]   r_hold;
    logic [c_os_w-1:0]    w_os_nxt;
    logic [c_q_w-1:0]     w_drop_nxt;
    logic [c_q_w-1:0]     w_q_cnt;
    logic [c_ent_w-1:0]   w_q_head;
    logic [c_ent_w-1:0]   w_head;
    logic [c_sum_w-1:0]   w_credit;
    logic                 w_run;
    logic                 w_ext_redir;
    logic                 w_redir;
    logic                 w_q_flush;
    logic [PC_W-1:0]      w_redir_pc;
    logic                 w_req_hs;
    logic                 w_rsp_hs;
    logic                 w_drop_rsp;
    logic                 w_push;
    logic                 w_pop;

    assign w_run       = (r_state == S_RUN);
    assign w_ext_redir = w_run && redirect_valid;

`ifdef IFU_JAL_PRED_EN
    logic              r_jal_pend;
    logic [PC_W-1:0]   r_jal_tgt;
    logic [PC_W-1:0]   w_jal_imm;
    logic              w_int_redir;

    // J-type immediate of the response being enqueued, sign-extended to PC_W
    assign w_jal_imm = {{(PC_W-21){ifu_rsp_instr[31]}}, ifu_rsp_instr[31],
                        ifu_rsp_instr[19:12], ifu_rsp_instr[20],
                        ifu_rsp_instr[30:21], 1'b0};

    // External redirect overrides a pending JAL redirect
    assign w_int_redir = r_jal_pend && !redirect_valid;
    assign w_redir     = w_ext_redir || w_int_redir;
    assign w_redir_pc  = w_ext_redir ? redirect_pc : r_jal_tgt;
    // The JAL is the youngest queued entry when its redirect fires, so only
    // the same-cycle response needs discarding; the queue is kept
    assign w_q_flush   = w_ext_redir;

    // Remember an enqueued JAL and its target for next-cycle redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_jal_pend <= 1'b0;
            r_jal_tgt  <= '0;
        end else begin
            r_jal_pend <= w_push && (ifu_rsp_instr[6:0] == c_opc_jal);
            r_jal_tgt  <= (r_rsp_pc + w_jal_imm) & c_align;
        end
    end
`else
    assign w_redir    = w_ext_redir;
    assign w_redir_pc = redirect_pc;
    assign w_q_flush  = w_ext_redir;
`endif

    // Credit rule: queued entries plus in-flight requests never exceed DEPTH
    assign w_credit      = c_sum_w'(w_q_cnt) + c_sum_w'(r_os_cnt);
    assign ifu_req_valid = w_run && (r_os_cnt < c_os_w'(MAX_OS)) &&
                           (w_credit < c_sum_w'(DEPTH)) && !w_redir;
    assign ifu_req_pc    = r_fetch_pc;
    assign ifu_rsp_ready = w_run;

    assign w_req_hs   = ifu_req_valid && ifu_req_ready;
    assign w_rsp_hs   = ifu_rsp_valid && ifu_rsp_ready;
    assign w_drop_rsp = w_rsp_hs && (r_drop_cnt != '0);
    assign w_push     = w_rsp_hs && !w_drop_rsp && !w_redir;

    assign ifu_o_valid  = (w_q_cnt != '0);
    assign ifu_o_pc_vld = ifu_o_valid;
    assign w_pop        = ifu_o_valid && ifu_o_ready;
    assign w_head       = ifu_o_valid ? w_q_head : r_hold;
    assign ifu_o_ir     = w_head[c_ent_w-1:PC_W];
    assign ifu_o_pc     = w_head[PC_W-1:0];
    assign ifu_o_rs1idx = RFIDX_W'(ifu_o_ir[19:15]);
    assign ifu_o_rs2idx = RFIDX_W'(ifu_o_ir[24:20]);

    ifu_pfq #(
        .WIDTH (c_ent_w),
        .DEPTH (DEPTH)
    ) u_pfq (
        .clk       (clk),
        .rst       (rst),
        .flush     (w_q_flush),
        .push      (w_push),
        .push_data ({ifu_rsp_instr, r_rsp_pc}),
        .pop       (w_pop),
        .head_data (w_q_head),
        .count     (w_q_cnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: BOOT lasts exactly one cycle after reset release
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // Outstanding and drop counters; after a redirect every response still in
    // flight is stale. Earlier pending drops are already part of os, so the
    // new drop count is simply the post-cycle outstanding count.
    always_comb begin
        w_os_nxt = r_os_cnt;
        if (w_req_hs) begin
            w_os_nxt = w_os_nxt + c_os_w'(1);
        end
        if (w_rsp_hs) begin
            w_os_nxt = w_os_nxt - c_os_w'(1);
        end
        w_drop_nxt = r_drop_cnt;
        if (w_drop_rsp) begin
            w_drop_nxt = r_drop_cnt - c_q_w'(1);
        end
        if (w_redir) begin
            w_drop_nxt = c_q_w'(w_os_nxt);
        end
    end

    // Fetch/response PCs, counters and the head-hold register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= '0;
            r_rsp_pc   <= '0;
            r_os_cnt   <= '0;
            r_drop_cnt <= '0;
            r_hold     <= '0;
        end else begin
            if (ifu_o_valid) begin
                r_hold <= w_q_head;
            end
            if (r_state == S_BOOT) begin
                r_fetch_pc <= pc_rtvec & c_align;
                r_rsp_pc   <= pc_rtvec & c_align;
            end else begin
                r_os_cnt   <= w_os_nxt;
                r_drop_cnt <= w_drop_nxt;
                if (w_redir) begin
                    r_fetch_pc <= w_redir_pc & c_align;
                    r_rsp_pc   <= w_redir_pc & c_align;
                end else begin
                    if (w_req_hs) begin
                        r_fetch_pc <= r_fetch_pc + c_inc;
                    end
                    if (w_push) begin
                        r_rsp_pc <= r_rsp_pc + c_inc;
                    end
                end
            end
        end
    end

endmodule : ifu_prefetch
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_prefetch
// Description : Self-checking bench for ifu_prefetch. A behavioural memory
//               answers requests in order; a program-order model predicts
//               every PC/instruction the EXU must receive.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_prefetch;
    import ifu_prefetch_pkg::*;

    localparam int DEPTH  = 4;
    localparam int MAX_OS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_rtvec;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rsp_instr;
    logic        ifu_o_valid;
    logic        ifu_o_ready;
    logic [31:0] ifu_o_ir;
    logic [31:0] ifu_o_pc;
    logic [4:0]  ifu_o_rs1idx;
    logic [4:0]  ifu_o_rs2idx;
    logic        ifu_o_pc_vld;

    ifu_prefetch #(
        .PC_W(32), .INSTR_W(32), .RFIDX_W(5), .DEPTH(DEPTH), .MAX_OS(MAX_OS)
    ) dut (
        .clk(clk), .rst(rst), .pc_rtvec(pc_rtvec),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_pc(ifu_req_pc), .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_instr(ifu_rsp_instr),
        .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready),
        .ifu_o_ir(ifu_o_ir), .ifu_o_pc(ifu_o_pc),
        .ifu_o_rs1idx(ifu_o_rs1idx), .ifu_o_rs2idx(ifu_o_rs2idx),
        .ifu_o_pc_vld(ifu_o_pc_vld)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int p_req, p_rsp, p_o;

    logic [31:0] exp_pc;
    logic [31:0] last_deq_pc;
    logic [31:0] mem_q[$];
    logic [31:0] special_addr  = 32'h1;
    logic [31:0] special_instr = 32'h0;

    logic        s_req_valid, s_req_hs, s_rsp_ready, s_rsp_hs;
    logic        s_o_valid, s_o_hs, s_pc_vld;
    logic [31:0] s_req_pc, s_o_pc, s_o_ir, s_exp_pc, s_exp_ir;
    logic [4:0]  s_rs1, s_rs2;

    // Program image: arbitrary non-branch instructions, one overridable word
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        logic [31:0] w;
        if (a == special_addr) return special_instr;
        w = (a * 32'h9E3779B1) ^ 32'h5A5A1234;
        w[6:0] = 7'b0010011;
        return w;
    endfunction

    // Architectural successor of an instruction as seen by the EXU
    function automatic logic [31:0] next_pc_of(input logic [31:0] pc, input logic [31:0] ir);
`ifdef IFU_JAL_PRED_EN
        if (ir[6:0] == c_opc_jal) begin
            int signed off;
            off = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            return (pc + off) & ~32'd3;
        end
`endif
        return pc + 32'd4;
    endfunction

    task automatic assert_rst(input logic [31:0] vec);
        @(negedge clk);
        rst = 1'b0;
        pc_rtvec = vec;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_instr = '0;
        ifu_o_ready = 1'b0;
        mem_q.delete();
        exp_pc = vec & ~32'd3;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock of stimulus: memory model, EXU ready, optional redirect,
    // sampling mid-cycle and advancing the program-order model
    task automatic step(input bit redir, input logic [31:0] rpc);
        ifu_req_ready = ($urandom_range(99) < p_req);
        ifu_o_ready   = ($urandom_range(99) < p_o);
        if (mem_q.size() > 0 && $urandom_range(99) < p_rsp) begin
            ifu_rsp_valid = 1'b1;
            ifu_rsp_instr = instr_of(mem_q[0]);
        end else begin
            ifu_rsp_valid = 1'b0;
            ifu_rsp_instr = $urandom;
        end
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        s_req_valid = ifu_req_valid;
        s_req_pc    = ifu_req_pc;
        s_rsp_ready = ifu_rsp_ready;
        s_o_valid   = ifu_o_valid;
        s_o_pc      = ifu_o_pc;
        s_o_ir      = ifu_o_ir;
        s_rs1       = ifu_o_rs1idx;
        s_rs2       = ifu_o_rs2idx;
        s_pc_vld    = ifu_o_pc_vld;
        s_req_hs    = ifu_req_valid && ifu_req_ready;
        s_rsp_hs    = ifu_rsp_valid && ifu_rsp_ready;
        s_o_hs      = ifu_o_valid && ifu_o_ready;
        s_exp_pc    = exp_pc;
        s_exp_ir    = instr_of(exp_pc);
        if (s_o_hs) begin
            exp_pc = next_pc_of(exp_pc, s_exp_ir);
            last_deq_pc = s_o_pc;
        end
        if (redir) exp_pc = rpc & ~32'd3;
        if (s_rsp_hs) void'(mem_q.pop_front());
        if (s_req_hs) mem_q.push_back(s_req_pc);
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] reqs[$];
        p_req = 100; p_rsp = 100; p_o = 100;
        assert_rst(32'h80000000);
        #1;
        n_checks++; if (ifu_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", ifu_req_valid); else n_pass++;
        n_checks++; if (ifu_req_pc !== 32'h0) $display("FAIL rst_req_pc: got %h want 0", ifu_req_pc); else n_pass++;
        n_checks++; if (ifu_rsp_ready !== 1'b0) $display("FAIL rst_rsp_ready: got %b want 0", ifu_rsp_ready); else n_pass++;
        n_checks++; if (ifu_o_valid !== 1'b0) $display("FAIL rst_o_valid: got %b want 0", ifu_o_valid); else n_pass++;
        n_checks++; if (ifu_o_pc !== 32'h0) $display("FAIL rst_o_pc: got %h want 0", ifu_o_pc); else n_pass++;
        n_checks++; if (ifu_o_ir !== 32'h0) $display("FAIL rst_o_ir: got %h want 0", ifu_o_ir); else n_pass++;
        n_checks++; if (ifu_o_pc_vld !== 1'b0) $display("FAIL rst_pc_vld: got %b want 0", ifu_o_pc_vld); else n_pass++;
        release_rst();
        #1;
        n_checks++; if (ifu_req_valid !== 1'b0) $display("FAIL boot_req_valid: got %b want 0", ifu_req_valid); else n_pass++;
        n_checks++; if (ifu_rsp_ready !== 1'b0) $display("FAIL boot_rsp_ready: got %b want 0", ifu_rsp_ready); else n_pass++;
        for (int i = 0; i < 14; i++) begin
            step(1'b0, '0);
            if (s_req_hs) reqs.push_back(s_req_pc);
            if (s_o_hs) begin
                n_checks++; if (s_o_pc !== s_exp_pc) $display("FAIL boot_o_pc: got %h want %h", s_o_pc, s_exp_pc); else n_pass++;
            end
            n_checks++; if (mem_q.size() > MAX_OS) $display("FAIL boot_os: got %0d want <= %0d", mem_q.size(), MAX_OS); else n_pass++;
        end
        n_checks++;
        if (reqs.size() < 2) $display("FAIL boot_req_count: got %0d want >= 2", reqs.size());
        else if (reqs[0] !== 32'h80000000 || reqs[1] !== 32'h80000004)
            $display("FAIL boot_req_seq: got %h,%h want 80000000,80000004", reqs[0], reqs[1]);
        else n_pass++;
        n_checks++; if (exp_pc === 32'h80000000) $display("FAIL boot_progress: got no deliveries want some"); else n_pass++;
    endtask

    task automatic test_full();
        int nreq;
        assert_rst(32'h80000000);
        release_rst();
        p_req = 100; p_rsp = 100; p_o = 0;
        nreq = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, '0);
            if (s_req_hs) nreq++;
        end
        n_checks++; if (nreq != DEPTH) $display("FAIL full_req_count: got %0d want %0d", nreq, DEPTH); else n_pass++;
        n_checks++; if (s_req_valid !== 1'b0) $display("FAIL full_req_valid: got %b want 0", s_req_valid); else n_pass++;
        n_checks++; if (s_o_valid !== 1'b1) $display("FAIL full_o_valid: got %b want 1", s_o_valid); else n_pass++;
        p_o = 100;
        step(1'b0, '0);
        n_checks++; if (s_o_hs !== 1'b1 || s_o_pc !== 32'h80000000) $display("FAIL full_deq: got hs=%b pc=%h want hs=1 pc=80000000", s_o_hs, s_o_pc); else n_pass++;
        p_o = 0;
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0);
            if (s_req_hs) nreq++;
        end
        n_checks++; if (nreq != 1) $display("FAIL full_refill: got %0d want 1", nreq); else n_pass++;
    endtask

    task automatic test_redirect();
        bit got;
        assert_rst(32'h80000000);
        release_rst();
        p_req = 100; p_rsp = 0; p_o = 100;
        repeat (3) step(1'b0, '0);
        n_checks++; if (mem_q.size() != 2) $display("FAIL redir_os: got %0d want 2", mem_q.size()); else n_pass++;
        step(1'b1, 32'h80001002);
        n_checks++; if (s_req_valid !== 1'b0) $display("FAIL redir_req_low: got %b want 0", s_req_valid); else n_pass++;
        p_rsp = 100;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(1'b0, '0);
            got = s_o_hs;
        end
        n_checks++;
        if (!got) $display("FAIL redir_timeout: got no delivery want one within 40 cycles");
        else if (s_o_pc !== 32'h80001000 || s_o_ir !== instr_of(32'h80001000))
            $display("FAIL redir_first: got pc=%h ir=%h want pc=80001000 ir=%h", s_o_pc, s_o_ir, instr_of(32'h80001000));
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0);
            if (s_o_hs) begin
                n_checks++; if (s_o_pc !== s_exp_pc) $display("FAIL redir_seq: got %h want %h", s_o_pc, s_exp_pc); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        bit got;
        assert_rst(32'h80000000);
        release_rst();
        p_req = 100; p_rsp = 100; p_o = 100;
        repeat (6) step(1'b0, '0);
        step(1'b1, 32'h80004000);
        n_checks++; if (s_rsp_hs !== 1'b1) $display("FAIL b2b_rsp_coincide: got %b want 1", s_rsp_hs); else n_pass++;
        n_checks++; if (s_req_valid !== 1'b0) $display("FAIL b2b_req_low: got %b want 0", s_req_valid); else n_pass++;
        step(1'b1, 32'h80005006);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(1'b0, '0);
            got = s_o_hs;
        end
        n_checks++;
        if (!got) $display("FAIL b2b_timeout: got no delivery want one within 40 cycles");
        else if (s_o_pc !== 32'h80005004) $display("FAIL b2b_first: got %h want 80005004", s_o_pc);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0);
            if (s_o_hs) begin
                n_checks++; if (s_o_pc !== s_exp_pc || s_o_ir !== s_exp_ir) $display("FAIL b2b_seq: got %h/%h want %h/%h", s_o_pc, s_o_ir, s_exp_pc, s_exp_ir); else n_pass++;
            end
        end
    endtask

    task automatic test_stream();
        bit rd;
        assert_rst(32'h7FFFFFF0);
        release_rst();
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) begin
                p_req = $urandom_range(100, 20);
                p_rsp = $urandom_range(100, 20);
                p_o   = $urandom_range(100, 10);
            end
            rd = (i > 2) && ($urandom_range(99) < 4);
            step(rd, $urandom);
            if (s_o_hs) begin
                n_checks++; if (s_o_pc !== s_exp_pc) $display("FAIL stream_pc: got %h want %h", s_o_pc, s_exp_pc); else n_pass++;
                n_checks++; if (s_o_ir !== s_exp_ir) $display("FAIL stream_ir: got %h want %h", s_o_ir, s_exp_ir); else n_pass++;
                n_checks++; if (s_rs1 !== s_exp_ir[19:15] || s_rs2 !== s_exp_ir[24:20])
                    $display("FAIL stream_rsidx: got %0d,%0d want %0d,%0d", s_rs1, s_rs2, s_exp_ir[19:15], s_exp_ir[24:20]); else n_pass++;
            end
            n_checks++; if (s_pc_vld !== s_o_valid) $display("FAIL stream_pc_vld: got %b want %b", s_pc_vld, s_o_valid); else n_pass++;
            n_checks++; if (mem_q.size() > MAX_OS) $display("FAIL stream_os: got %0d want <= %0d", mem_q.size(), MAX_OS); else n_pass++;
        end
    endtask

    task automatic test_decode();
        bit got;
        special_addr  = 32'h80002000;
        special_instr = 32'h00100093;
        p_req = 100; p_rsp = 100; p_o = 100;
        step(1'b1, 32'h80002000);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(1'b0, '0);
            got = s_o_hs && (s_o_pc == 32'h80002000);
        end
        n_checks++;
        if (!got) $display("FAIL decode_timeout: got no delivery of 80002000");
        else if (s_rs1 !== 5'd0 || s_rs2 !== 5'd1 || s_o_ir !== 32'h00100093)
            $display("FAIL decode_rsidx: got rs1=%0d rs2=%0d ir=%h want rs1=0 rs2=1 ir=00100093", s_rs1, s_rs2, s_o_ir);
        else n_pass++;
        p_req = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b0, '0);
            got = !s_o_valid;
        end
        n_checks++;
        if (!got) $display("FAIL empty_timeout: got o_valid stuck 1 want 0");
        else if (s_o_pc !== last_deq_pc) $display("FAIL empty_hold_pc: got %h want %h", s_o_pc, last_deq_pc);
        else n_pass++;
        special_addr = 32'h1;
    endtask

    task automatic test_jal();
        bit got;
        logic [31:0] want;
`ifdef IFU_JAL_PRED_EN
        want = 32'h80000010;
`else
        want = 32'h80000004;
`endif
        special_addr  = 32'h80000000;
        special_instr = 32'h0100006F;
        assert_rst(32'h80000000);
        release_rst();
        p_req = 100; p_rsp = 100; p_o = 100;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b0, '0);
            got = s_o_hs;
        end
        n_checks++; if (!got || s_o_pc !== 32'h80000000) $display("FAIL jal_first: got hs=%b pc=%h want pc=80000000", got, s_o_pc); else n_pass++;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(1'b0, '0);
            got = s_o_hs;
        end
        n_checks++; if (!got || s_o_pc !== want) $display("FAIL jal_next: got hs=%b pc=%h want %h", got, s_o_pc, want); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0);
            if (s_o_hs) begin
                n_checks++; if (s_o_pc !== s_exp_pc) $display("FAIL jal_seq: got %h want %h", s_o_pc, s_exp_pc); else n_pass++;
            end
        end
        special_addr = 32'h1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        test_reset();
        test_full();
        test_redirect();
        test_back_to_back();
        test_stream();
        test_decode();
        test_jal();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ifu_prefetch
`default_nettype wire
